mainm_arbiter: RTL

//  Two-requester arbiter for the single main-memory (PSRAM) port. Sits between
//  the serialboot CPU-side main-memory bus (master 0, CPU) plus a second bus

---
 rtl/mainm_arbiter_pkg.sv | 18 +
 rtl/mainm_arbiter_rr_pick2.sv | 19 +
 rtl/mainm_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mainm_arbiter_pkg.sv
// Shared encodings for the main-memory arbiter: FSM states and the
// read data returned to a master when an access is abandoned by the watchdog.
package mainm_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hFFFF_FFFF;

  // A write and a read held together count as one request (served as a write).
  function automatic logic is_req(input logic we, input logic rd);
    return we | rd;
  endfunction

endpackage

// File: rtl/mainm_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the master that was
// not served last wins; a lone requester always wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/mainm_arbiter.sv
// Two-master round-robin arbiter for the single main-memory (PSRAM) port.
// Build option: define MAINM_ARB_TIMEOUT_EN for the BUSY watchdog and irq.
module mainm_arbiter
  import mainm_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  input  logic        m0_rd,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  input  logic        m1_rd,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic [31:0] s_a,
  output logic [31:0] s_d,
  output logic        s_we,
  output logic        s_rd,
  input  logic [31:0] s_spo,
  input  logic        s_ready,
  output logic        irq,
  output logic [1:0]  dbg_state
);

  // Handshake: a master holds we/rd (and a/d) as a level until its ready
  // pulse; ready is a one-cycle pulse with spo valid in that same cycle.
  // Dropping the request before ready abandons the access without a pulse.

  arb_state_t  state_q, state_d;
  logic        grant_q;
  logic        last_q;
  logic        pick;
  logic [1:0]  req;
  logic        owner_req;
  logic        done;
  logic        abort;
  logic        tmo_hit;
  logic [31:0] rsp_data;

  assign req       = {is_req(m1_we, m1_rd), is_req(m0_we, m0_rd)};
  assign owner_req = grant_q ? req[1] : req[0];
  assign rsp_data  = s_ready ? s_spo : ARB_TIMEOUT_DATA;
  assign dbg_state = state_q;

  rr_pick2 u_pick (
    .req   (req),
    .last  (last_q),
    .grant (pick)
  );

`ifdef MAINM_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             irq_q;

  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign irq     = irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      if (state_q == ARB_BUSY && state_d == ARB_BUSY) cnt_q <= cnt_q + 1'b1;
      else                                           cnt_q <= '0;
      if (done && !s_ready) irq_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign irq     = 1'b0;
`endif

  // Abort wins over a same-cycle s_ready: the requester has already left.
  always_comb begin
    state_d  = state_q;
    done     = 1'b0;
    abort    = 1'b0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_spo   = '0;
    m1_spo   = '0;
    case (state_q)
      ARB_IDLE: if (|req) state_d = ARB_BUSY;
      ARB_BUSY: begin
        if (!owner_req) begin
          abort   = 1'b1;
          state_d = ARB_GAP;
        end else if (s_ready || tmo_hit) begin
          done    = 1'b1;
          state_d = ARB_GAP;
        end
      end
      ARB_GAP:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
    if (done && !rst) begin
      if (grant_q) begin
        m1_ready = 1'b1;
        m1_spo   = rsp_data;
      end else begin
        m0_ready = 1'b1;
        m0_spo   = rsp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      s_a     <= '0;
      s_d     <= '0;
      s_we    <= 1'b0;
      s_rd    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && |req) begin
        grant_q <= pick;
        s_a     <= pick ? m1_a : m0_a;
        s_d     <= pick ? m1_d : m0_d;
        s_we    <= pick ? m1_we : m0_we;
        s_rd    <= pick ? (m1_rd & ~m1_we) : (m0_rd & ~m0_we);
      end
      if (done || abort) begin
        s_we <= 1'b0;
        s_rd <= 1'b0;
      end
      if (done) last_q <= grant_q;
    end
  end

endmodule
